vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Generates VGA raster timing: pixel coordinates, line/frame strobes, hsync/vsync.
//  Drives the x, y, newline and newframe inputs of the text/char renderer, and
//  the sync pins. Sits between the pixel clock enable and the renderer, once per display.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   hsync width, pixels
//  H_BP      48   horizontal back porch, pixels
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vsync width, lines
//  V_BP      33   vertical back porch, lines
//  HS_POL    0    hsync active level
//  VS_POL    0    vsync active level
// PORTS
//  clk       in   1   system clock, single clock domain
//  rst       in   1   synchronous reset, active-high
//  pix_en    in   1   pixel-advance enable; may be tied to 1
//  x         out  10  current horizontal position, 0..H_TOTAL-1
//  y         out  10  current vertical position, 0..V_TOTAL-1
//  active    out  1   x<H_ACTIVE && y<V_ACTIVE
//  newline   out  1   one-clk pulse, first pixel of every line (x==0)
//  newframe  out  1   one-clk pulse at (0,0), coincident with newline
//  hsync     out  1   horizontal sync, level HS_POL when asserted
//  vsync     out  1   vertical sync, level VS_POL when asserted
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way. Either >1023 is an elaboration error.
//  - All outputs are registered. Reset values: x=0, y=0, active=0, newline=0, newframe=0,
//    hsync=~HS_POL, vsync=~VS_POL. Internal h_cnt=0, v_cnt=0, H FSM=ACT, V FSM=ACT.
//  - On each clk with pix_en=1, the outputs load the values decoded from (h_cnt,v_cnt).
//    The counters then advance, so latency from counter to pins is 1 clk.
//  - With pix_en=0, x/y/active/hsync/vsync hold. newline/newframe are 0 in any clk that
//    does not load x==0, so each pulse is exactly 1 clk wide for any pix_en pattern.
//  - First pix_en after reset release emits (0,0): newline=newframe=1, active=1.
//  - Counter wrap: h_cnt==H_TOTAL-1 -> 0 with v_cnt+1. If v_cnt==V_TOTAL-1 as well,
//    both counters go to 0.
//  - Per-axis FSM ACT->FP->SYNC->BP->ACT. Transitions happen at the counter boundaries
//    H_ACTIVE, +H_FP, +H_SYNC and wrap. The V FSM steps only on horizontal wrap.
//  - hsync is asserted when H FSM==SYNC. vsync is asserted when V FSM==SYNC, for whole lines.
//  - rst has priority over pix_en. Reset mid-frame returns all outputs to reset values
//    on the next clk, and the raster restarts at (0,0).
// CONFIGURATION
//  - VGA_TEST_PATTERN_EN defined: adds outputs pat_r/pat_g/pat_b (1 bit each).
//    During active, {pat_r,pat_g,pat_b} = x[9:7], giving colour bars 128 px wide.
//    Outside active they are 000. They are registered and aligned with x/y; reset value is 000.
//  - VGA_TEST_PATTERN_EN undefined: these ports and their logic are absent. All other
//    behaviour is identical.
// STRUCTURE
//  - vga_timing_pkg holds the 640x480@60 default constants and the typedef
//    axis_state_t {ACT,FP,SYNC,BP}.
//  - Sub-module vga_axis_counter(ACTIVE,FP,SYNC,BP) provides counter, axis FSM, wrap flag
//    and sync decode. It is instantiated twice: h, stepped by pix_en; v, stepped by the h wrap.
// TESTING
//  1 rst 3 clk, release, pix_en=1 -> 1st clk (0,0), newline=newframe=1, active=1,
//    hsync=1 for x 0..655, hsync=0 for x 656..751.
//  2 run to x=799,y=10 -> next clk x=0,y=11, newline=1, newframe=0. active=0 for x>=640.
//  3 run to x=799,y=524 -> next clk (0,0), newframe=1. vsync=0 only on y=490,491.
//  4 pix_en toggled 1,0,1,0 -> x steps every 2 clk, one line=1600 clk, newline 1 clk wide.
//  5 rst pulse at (300,200) mid-line -> next clk all outputs at reset values. First
//    pix_en after release emits (0,0) with newframe=1.
//  6 with VGA_TEST_PATTERN_EN: x=130,y=5 -> rgb=001; x=600 -> 100; x=700 -> 000.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// VGA timing package: 640x480@60 default constants and axis FSM state type.
// Shared by vga_axis_counter and vga_timing_gen.
package vga_timing_pkg;

  localparam int CNT_W      = 10;
  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  typedef enum logic [1:0] {
    ST_ACT,
    ST_FP,
    ST_SYNC,
    ST_BP
  } axis_state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter, ACT/FP/SYNC/BP FSM, last flag, sync decode.
// Ports: clk, rst (sync, high), step in; cnt, state, last, in_sync out.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output axis_state_t      state,
  output logic             last,
  output logic             in_sync
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [CNT_W-1:0] E_ACT =
    CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] E_FP =
    CNT_W'(ACTIVE + FP - 1);
  localparam logic [CNT_W-1:0] E_SYNC =
    CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] E_LAST =
    CNT_W'(TOTAL - 1);

  generate
    if (TOTAL > 1023) begin : g_too_big
      $error("vga_axis_counter: total exceeds 1023");
    end
  endgenerate

  assign last    = (cnt == E_LAST);
  assign in_sync = (state == ST_SYNC);

  // State always describes the current cnt, so it moves
  // on the same step that crosses a region boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      state <= ST_ACT;
    end else if (step) begin
      cnt <= last ? '0 : cnt + CNT_W'(1);
      unique case (state)
        ST_ACT:  if (cnt == E_ACT)  state <= ST_FP;
        ST_FP:   if (cnt == E_FP)   state <= ST_SYNC;
        ST_SYNC: if (cnt == E_SYNC) state <= ST_BP;
        ST_BP:   if (last)          state <= ST_ACT;
        default: state <= ST_ACT;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: registered x/y, active, newline/newframe, hsync/vsync.
// Ports: clk, rst, pix_en in; x, y, active, newline, newframe, hsync, vsync
// out; pat_r/pat_g/pat_b out only when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_D,
  parameter int   H_FP     = H_FP_D,
  parameter int   H_SYNC   = H_SYNC_D,
  parameter int   H_BP     = H_BP_D,
  parameter int   V_ACTIVE = V_ACTIVE_D,
  parameter int   V_FP     = V_FP_D,
  parameter int   V_SYNC   = V_SYNC_D,
  parameter int   V_BP     = V_BP_D,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             active,
  output logic             newline,
  output logic             newframe,
`ifdef VGA_TEST_PATTERN_EN
  output logic             pat_r,
  output logic             pat_g,
  output logic             pat_b,
`endif
  output logic             hsync,
  output logic             vsync
);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  axis_state_t      h_state;
  axis_state_t      v_state;
  logic             h_last;
  logic             v_last;
  logic             h_sync;
  logic             v_sync;
  logic             v_step;
  logic             act_d;
  logic             unused_v_last;

  assign v_step        = pix_en & h_last;
  assign unused_v_last = v_last;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h (
    .clk     (clk),
    .rst     (rst),
    .step    (pix_en),
    .cnt     (h_cnt),
    .state   (h_state),
    .last    (h_last),
    .in_sync (h_sync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v (
    .clk     (clk),
    .rst     (rst),
    .step    (v_step),
    .cnt     (v_cnt),
    .state   (v_state),
    .last    (v_last),
    .in_sync (v_sync)
  );

  assign act_d = (h_state == ST_ACT) &&
                 (v_state == ST_ACT);

  // Pins show the counter value one clk later; strobes
  // drop in any clk that does not load a new x==0.
  always_ff @(posedge clk) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      active   <= 1'b0;
      newline  <= 1'b0;
      newframe <= 1'b0;
      hsync    <= ~HS_POL;
      vsync    <= ~VS_POL;
`ifdef VGA_TEST_PATTERN_EN
      {pat_r, pat_g, pat_b} <= 3'b000;
`endif
    end else if (pix_en) begin
      x        <= h_cnt;
      y        <= v_cnt;
      active   <= act_d;
      newline  <= (h_cnt == '0);
      newframe <= (h_cnt == '0) && (v_cnt == '0);
      hsync    <= h_sync ? HS_POL : ~HS_POL;
      vsync    <= v_sync ? VS_POL : ~VS_POL;
`ifdef VGA_TEST_PATTERN_EN
      {pat_r, pat_g, pat_b} <= act_d ? h_cnt[9:7]
                                     : 3'b000;
`endif
    end else begin
      newline  <= 1'b0;
      newframe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: 640x480 instance plus a tiny
// raster instance (15x13, positive sync) used for frame wrap and vsync.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_en = 1'b0;

  logic [9:0] x, y;
  logic       active, newline, newframe, hsync, vsync;
  logic [9:0] s_x, s_y;
  logic       s_act, s_nl, s_nf, s_hs, s_vs;
`ifdef VGA_TEST_PATTERN_EN
  logic       pr, pg, pb, s_pr, s_pg, s_pb;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk      (clk),
    .rst      (rst),
    .pix_en   (pix_en),
    .x        (x),
    .y        (y),
    .active   (active),
    .newline  (newline),
    .newframe (newframe),
`ifdef VGA_TEST_PATTERN_EN
    .pat_r    (pr),
    .pat_g    (pg),
    .pat_b    (pb),
`endif
    .hsync    (hsync),
    .vsync    (vsync)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (3),
    .HS_POL   (1'b1), .VS_POL (1'b1)
  ) dut_s (
    .clk      (clk),
    .rst      (rst),
    .pix_en   (pix_en),
    .x        (s_x),
    .y        (s_y),
    .active   (s_act),
    .newline  (s_nl),
    .newframe (s_nf),
`ifdef VGA_TEST_PATTERN_EN
    .pat_r    (s_pr),
    .pat_g    (s_pg),
    .pat_b    (s_pb),
`endif
    .hsync    (s_hs),
    .vsync    (s_vs)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_x"},  32'(x), 0);
    check({tag, "_y"},  32'(y), 0);
    check({tag, "_act"}, 32'(active), 0);
    check({tag, "_nl"}, 32'(newline), 0);
    check({tag, "_nf"}, 32'(newframe), 0);
    check({tag, "_hs"}, 32'(hsync), 1);
    check({tag, "_vs"}, 32'(vsync), 1);
  endtask

  initial begin
    int errs;
    int nl_cnt;
    int vs_cnt;
    int ex, ey;

    // 1: reset, then first pixel and line-0 hsync window
    rst = 1'b1; pix_en = 1'b0;
    repeat (3) tick();
    check_reset("rst");
    check("rst_s_hs", 32'(s_hs), 0);
    rst = 1'b0; pix_en = 1'b1;
    tick();
    check("p0_x", 32'(x), 0);
    check("p0_y", 32'(y), 0);
    check("p0_nl", 32'(newline), 1);
    check("p0_nf", 32'(newframe), 1);
    check("p0_act", 32'(active), 1);
    check("p0_hs", 32'(hsync), 1);
    errs = 0;
    for (int i = 1; i < 800; i++) begin
      tick();
      if (x !== 10'(i)) errs++;
      if (hsync !== ((i < 656) || (i >= 752))) errs++;
      if (active !== (i < 640)) errs++;
      if (newline !== 1'b0 || newframe !== 1'b0) errs++;
    end
    check("line0_errs", errs, 0);

    // 2: line wrap at (799,10)
    repeat (8000) tick();
    check("l10_x", 32'(x), 799);
    check("l10_y", 32'(y), 10);
    tick();
    check("l11_x", 32'(x), 0);
    check("l11_y", 32'(y), 11);
    check("l11_nl", 32'(newline), 1);
    check("l11_nf", 32'(newframe), 0);
    check("l11_vs", 32'(vsync), 1);
    repeat (639) tick();
    check("x639_act", 32'(active), 1);
    tick();
    check("x640_x", 32'(x), 640);
    check("x640_act", 32'(active), 0);
    check("x640_nl", 32'(newline), 0);
    repeat (159) tick();
    check("l11_end_x", 32'(x), 799);

    // 4: pix_en 1,0,1,0: x advances every 2 clk
    errs = 0; nl_cnt = 0;
    for (int k = 0; k < 1600; k++) begin
      pix_en = (k % 2 == 0);
      tick();
      if (x !== 10'(k / 2)) errs++;
      if (y !== 10'd12) errs++;
      if (newline) nl_cnt++;
      if (newline !== (k == 0)) errs++;
    end
    check("toggle_errs", errs, 0);
    check("toggle_nl_cnt", nl_cnt, 1);
    check("toggle_end_x", 32'(x), 799);
    pix_en = 1'b1;
    tick();
    check("l13_x", 32'(x), 0);
    check("l13_y", 32'(y), 13);
    check("l13_nl", 32'(newline), 1);
    pix_en = 1'b0;
    tick();
    check("hold_nl", 32'(newline), 0);
    check("hold_x", 32'(x), 0);

    // 5: reset mid-line, rst wins over pix_en
    pix_en = 1'b1;
    repeat (300) tick();
    check("mid_x", 32'(x), 300);
    rst = 1'b1;
    tick();
    check_reset("mid_rst");
    rst = 1'b0; pix_en = 1'b0;
    tick();
    check_reset("idle");
    pix_en = 1'b1;
    tick();
    check("rs_x", 32'(x), 0);
    check("rs_y", 32'(y), 0);
    check("rs_nl", 32'(newline), 1);
    check("rs_nf", 32'(newframe), 1);
    check("rs_act", 32'(active), 1);

    // 6: colour bars
    repeat (4130) tick();
    check("pat_x130", 32'(x), 130);
    check("pat_y5", 32'(y), 5);
`ifdef VGA_TEST_PATTERN_EN
    check("rgb_130", 32'({pr, pg, pb}), 1);
`endif
    repeat (470) tick();
    check("pat_x600", 32'(x), 600);
`ifdef VGA_TEST_PATTERN_EN
    check("rgb_600", 32'({pr, pg, pb}), 4);
`endif
    repeat (100) tick();
    check("pat_x700", 32'(x), 700);
`ifdef VGA_TEST_PATTERN_EN
    check("rgb_700", 32'({pr, pg, pb}), 0);
`endif

    // 3: small raster, two full frames (15 x 13)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    errs = 0; vs_cnt = 0;
    for (int t = 0; t < 390; t++) begin
      tick();
      ex = t % 15;
      ey = (t / 15) % 13;
      if (s_x !== 10'(ex) || s_y !== 10'(ey)) errs++;
      if (s_act !== (ex < 8 && ey < 6)) errs++;
      if (s_nl !== (ex == 0)) errs++;
      if (s_nf !== (ex == 0 && ey == 0)) errs++;
      if (s_hs !== (ex >= 10 && ex <= 12)) errs++;
      if (s_vs !== (ey >= 8 && ey <= 9)) errs++;
      if (s_vs) vs_cnt++;
      if (t == 194) begin
        check("s_end_x", 32'(s_x), 14);
        check("s_end_y", 32'(s_y), 12);
      end
      if (t == 195) begin
        check("s_wrap_nf", 32'(s_nf), 1);
        check("s_wrap_y", 32'(s_y), 0);
      end
    end
    check("small_errs", errs, 0);
    check("small_vs_cnt", vs_cnt, 60);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
